ysyx_23060240_trap_ctrl: RTL and testbench
==========================================

// Module: ysyx_23060240_trap_ctrl
// PURPOSE
//  Trap sequencer upstream of the CSR file. Accepts ecall / mret / illegal-instr events from
//  EXU, performs the required CSR updates one per cycle through the CSR file's single write
//  port, reads the redirect target, and hands the new PC to IFU.
//  Holds the pipeline (busy) for the whole sequence.
// PARAMETERS
//  XLEN          32     data/PC width
//  CAUSE_ECALL   32'd11 mcause written for ecall from M-mode
//  CAUSE_ILLEGAL 32'd2  mcause written for illegal instruction
//  MPP_VALUE     2'b11  value forced into mstatus.MPP; M-only core
// PORTS
//  clk             in   1     single clock; all state updates on posedge
//  rst             in   1     asynchronous, active-high reset
//  trap_valid      in   1     EXU presents a trap event
//  trap_ready      out  1     controller can accept an event (state==IDLE)
//  trap_is_ecall   in   1     event kind: ecall
//  trap_is_mret    in   1     event kind: mret
//  trap_is_illegal in   1     event kind: illegal instruction
//  trap_pc         in   XLEN  PC of the trapping instruction
//  csr_wen         out  1     CSR write strobe; one CSR per cycle
//  csr_waddr       out  12    CSR write address
//  csr_wdata       out  XLEN  CSR write data
//  csr_raddr       out  12    CSR read address; combinational read
//  csr_rdata       in   XLEN  CSR read data; same cycle
//  redirect_valid  out  1     new PC available for IFU
//  redirect_pc     out  XLEN  new PC
//  redirect_ready  in   1     IFU accepts redirect
//  busy            out  1     state!=IDLE; stall fetch/decode
// BEHAVIOUR
//  Reset: state=IDLE; csr_wen=0, csr_waddr=0, csr_wdata=0, csr_raddr=0, redirect_valid=0,
//   redirect_pc=0, busy=0, trap_ready=1; latched pc/kind/target cleared.
//  Accept: trap_valid&trap_ready at posedge. Latch trap_pc and kind.
//   Kind priority: illegal > ecall > mret.
//   trap_valid with no kind bit set is ignored (no state change).
//  Trap path (ecall/illegal): IDLE->W_EPC->W_CAUSE->W_STATUS->R_VEC->REDIR
//   W_EPC:    wen=1, waddr=0x341, wdata=pc_q
//   W_CAUSE:  wen=1, waddr=0x342, wdata=CAUSE_ECALL or CAUSE_ILLEGAL
//   W_STATUS: raddr=0x300, wen=1, waddr=0x300.
//     wdata=rdata with MPIE(7)<=MIE(3), MIE<=0, MPP(12:11)<=MPP_VALUE.
//   R_VEC:    raddr=0x305; target_q<=rdata&~32'h3 at edge (direct mode only)
//  mret path: IDLE->M_STATUS->R_EPC->REDIR
//   M_STATUS: raddr=0x300, wen=1.
//     wdata=rdata with MIE<=MPIE, MPIE<=1, MPP<=MPP_VALUE.
//   R_EPC:    raddr=0x341; target_q<=rdata at edge.
//  REDIR: redirect_valid=1, redirect_pc=target_q, both held stable until redirect_ready.
//   -> IDLE on the edge where redirect_ready=1.
//  Latency from accept edge to first redirect_valid=1 cycle: 5 cycles (trap), 3 cycles (mret).
//   With redirect_ready tied high, next accept is possible 1 cycle after REDIR.
//  csr_wen=0 and csr_raddr=0 in any state not listed above.
//   Never more than one CSR write per cycle.
//  trap_valid while busy: not accepted (trap_ready=0). EXU must hold it.
//  Reset mid-sequence: immediate return to IDLE, all outputs go to reset values.
//   CSR writes already issued are not undone. No redirect is issued.
//  Unused kinds / illegal state encodings: go to IDLE.
// STRUCTURE
//  Shared package ysyx_23060240_csr_pkg holds:
//   - CSR addresses (MSTATUS 0x300, MTVEC 0x305, MEPC 0x341, MCAUSE 0x342)
//   - mstatus bit indices (MIE 3, MPIE 7, MPP 12:11)
//   - cause codes
//   - trap_state_e enum: IDLE, W_EPC, W_CAUSE, W_STATUS, R_VEC, M_STATUS, R_EPC, REDIR
//  Single module, one FSM plus pc_q/kind_q/target_q registers. No sub-module.
// TESTING
//  1. ecall, pc=0x8000_0100, mtvec=0x8000_0203, mstatus=0x0000_0008:
//     -> writes mepc=0x8000_0100, mcause=11, mstatus=0x0000_1880.
//     -> redirect_pc=0x8000_0200 in cycle 5.
//  2. mret, mepc=0x8000_0104, mstatus=0x0000_1880:
//     -> mstatus=0x0000_1888, redirect_pc=0x8000_0104 in cycle 3.
//  3. ecall+illegal asserted together -> mcause=2.
//     trap_valid with no kind bit -> no CSR write, trap_ready stays 1.
//  4. redirect_ready=0 for 4 cycles -> redirect_valid and redirect_pc stable;
//     second trap_valid held meanwhile is accepted only after the IDLE return.
//  5. rst pulsed while in W_STATUS -> outputs at reset values asynchronously.
//     mepc/mcause already written, no redirect, next ecall runs normally.
//  6. Checker on all runs: csr_wen never asserted in IDLE/REDIR; busy==!trap_ready.

Source files
------------

// File: rtl/ysyx_23060240_csr_pkg.sv
// CSR addresses, mstatus fields, cause codes and trap FSM types
// shared by the trap sequencer and its neighbours.
package ysyx_23060240_csr_pkg;

    localparam int XLEN = 32;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam int MIE_BIT  = 3;
    localparam int MPIE_BIT = 7;
    localparam int MPP_LO   = 11;
    localparam int MPP_HI   = 12;

    localparam logic [31:0] CAUSE_ECALL_DEF   = 32'd11;
    localparam logic [31:0] CAUSE_ILLEGAL_DEF = 32'd2;
    localparam logic [1:0]  MPP_VALUE_DEF     = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        W_EPC,
        W_CAUSE,
        W_STATUS,
        R_VEC,
        M_STATUS,
        R_EPC,
        REDIR
    } trap_state_e;

    typedef enum logic [1:0] {
        K_NONE,
        K_ECALL,
        K_ILLEGAL,
        K_MRET
    } trap_kind_e;

endpackage

// File: rtl/ysyx_23060240_trap_ctrl.sv
// Trap sequencer: walks ecall/illegal/mret through the single CSR
// write port one CSR per cycle, then hands the new PC to IFU.
module ysyx_23060240_trap_ctrl
    import ysyx_23060240_csr_pkg::*;
#(
    parameter int               XLEN_P        = XLEN,
    parameter logic [XLEN_P-1:0] CAUSE_ECALL   = XLEN_P'(CAUSE_ECALL_DEF),
    parameter logic [XLEN_P-1:0] CAUSE_ILLEGAL = XLEN_P'(CAUSE_ILLEGAL_DEF),
    parameter logic [1:0]       MPP_VALUE     = MPP_VALUE_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              trap_valid,
    output logic              trap_ready,
    input  logic              trap_is_ecall,
    input  logic              trap_is_mret,
    input  logic              trap_is_illegal,
    input  logic [XLEN_P-1:0] trap_pc,
    output logic              csr_wen,
    output logic [11:0]       csr_waddr,
    output logic [XLEN_P-1:0] csr_wdata,
    output logic [11:0]       csr_raddr,
    input  logic [XLEN_P-1:0] csr_rdata,
    output logic              redirect_valid,
    output logic [XLEN_P-1:0] redirect_pc,
    input  logic              redirect_ready,
    output logic              busy
);

    trap_state_e       state_q;
    trap_kind_e        kind_q;
    logic [XLEN_P-1:0] pc_q;
    logic [XLEN_P-1:0] target_q;
    logic [XLEN_P-1:0] status_trap_d;
    logic [XLEN_P-1:0] status_mret_d;

    // mstatus images for trap entry and mret, built from the live read
    always_comb begin
        status_trap_d = csr_rdata;
        status_trap_d[MPIE_BIT] = csr_rdata[MIE_BIT];
        status_trap_d[MIE_BIT] = 1'b0;
        status_trap_d[MPP_HI:MPP_LO] = MPP_VALUE;
        status_mret_d = csr_rdata;
        status_mret_d[MIE_BIT] = csr_rdata[MPIE_BIT];
        status_mret_d[MPIE_BIT] = 1'b1;
        status_mret_d[MPP_HI:MPP_LO] = MPP_VALUE;
    end

    // Sequencer FSM with latched pc, kind and redirect target
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            kind_q   <= K_NONE;
            pc_q     <= '0;
            target_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (trap_valid) begin
                        if (trap_is_illegal) begin
                            kind_q  <= K_ILLEGAL;
                            pc_q    <= trap_pc;
                            state_q <= W_EPC;
                        end else if (trap_is_ecall) begin
                            kind_q  <= K_ECALL;
                            pc_q    <= trap_pc;
                            state_q <= W_EPC;
                        end else if (trap_is_mret) begin
                            kind_q  <= K_MRET;
                            pc_q    <= trap_pc;
                            state_q <= M_STATUS;
                        end
                    end
                end
                W_EPC: begin
                    if (kind_q == K_ECALL || kind_q == K_ILLEGAL) begin
                        state_q <= W_CAUSE;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                W_CAUSE:  state_q <= W_STATUS;
                W_STATUS: state_q <= R_VEC;
                R_VEC: begin
                    target_q <= csr_rdata & ~XLEN_P'(3);
                    state_q  <= REDIR;
                end
                M_STATUS: state_q <= R_EPC;
                R_EPC: begin
                    target_q <= csr_rdata;
                    state_q  <= REDIR;
                end
                REDIR: begin
                    if (redirect_ready) begin
                        state_q <= IDLE;
                    end
                end
                default:  state_q <= IDLE;
            endcase
        end
    end

    // Per-state CSR port and redirect drive, decoded from the state register
    always_comb begin
        csr_wen        = 1'b0;
        csr_waddr      = '0;
        csr_wdata      = '0;
        csr_raddr      = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        case (state_q)
            W_EPC: begin
                csr_wen   = 1'b1;
                csr_waddr = CSR_MEPC;
                csr_wdata = pc_q;
            end
            W_CAUSE: begin
                csr_wen   = 1'b1;
                csr_waddr = CSR_MCAUSE;
                csr_wdata = (kind_q == K_ILLEGAL) ? CAUSE_ILLEGAL : CAUSE_ECALL;
            end
            W_STATUS: begin
                csr_raddr = CSR_MSTATUS;
                csr_wen   = 1'b1;
                csr_waddr = CSR_MSTATUS;
                csr_wdata = status_trap_d;
            end
            R_VEC: csr_raddr = CSR_MTVEC;
            M_STATUS: begin
                csr_raddr = CSR_MSTATUS;
                csr_wen   = 1'b1;
                csr_waddr = CSR_MSTATUS;
                csr_wdata = status_mret_d;
            end
            R_EPC: csr_raddr = CSR_MEPC;
            REDIR: begin
                redirect_valid = 1'b1;
                redirect_pc    = target_q;
            end
            default: ;
        endcase
    end

    assign busy       = (state_q != IDLE);
    assign trap_ready = (state_q == IDLE);

endmodule

// File: tb/tb_ysyx_23060240_trap_ctrl.sv
// Self-checking bench for the trap sequencer with a small CSR file
// model, directed vector table, corner sequences and random traffic.
module tb_ysyx_23060240_trap_ctrl;
    import ysyx_23060240_csr_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        trap_valid, trap_ready;
    logic        trap_is_ecall, trap_is_mret, trap_is_illegal;
    logic [31:0] trap_pc;
    logic        csr_wen;
    logic [11:0] csr_waddr, csr_raddr;
    logic [31:0] csr_wdata, csr_rdata;
    logic        redirect_valid, redirect_ready;
    logic [31:0] redirect_pc;
    logic        busy;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ysyx_23060240_trap_ctrl dut (
        .clk(clk), .rst(rst),
        .trap_valid(trap_valid), .trap_ready(trap_ready),
        .trap_is_ecall(trap_is_ecall), .trap_is_mret(trap_is_mret),
        .trap_is_illegal(trap_is_illegal), .trap_pc(trap_pc),
        .csr_wen(csr_wen), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
        .csr_raddr(csr_raddr), .csr_rdata(csr_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .redirect_ready(redirect_ready), .busy(busy)
    );

    logic [31:0] m_ms, m_tv, m_epc, m_cause;
    logic        ld;
    logic [31:0] ld_ms, ld_tv, ld_epc, ld_cause;
    logic [43:0] wq[$];
    logic [43:0] exp_q[$];

    // CSR file model: preload port plus DUT write port, logs writes
    always @(posedge clk) begin
        if (ld) begin
            m_ms <= ld_ms; m_tv <= ld_tv;
            m_epc <= ld_epc; m_cause <= ld_cause;
        end else if (csr_wen) begin
            wq.push_back({csr_waddr, csr_wdata});
            case (csr_waddr)
                12'h300: m_ms <= csr_wdata;
                12'h305: m_tv <= csr_wdata;
                12'h341: m_epc <= csr_wdata;
                12'h342: m_cause <= csr_wdata;
                default: ;
            endcase
        end
    end

    // Combinational CSR read
    always_comb begin
        case (csr_raddr)
            12'h300: csr_rdata = m_ms;
            12'h305: csr_rdata = m_tv;
            12'h341: csr_rdata = m_epc;
            12'h342: csr_rdata = m_cause;
            default: csr_rdata = 32'h0;
        endcase
    end

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    endtask

    // One cycle: advance to negedge, then check the standing invariants
    task automatic cyc();
        @(negedge clk);
        chk("busy_vs_ready", 32'(busy), 32'(!trap_ready));
        chk("wen_idle_redir", 32'(csr_wen && (trap_ready || redirect_valid)), 0);
    endtask

    task automatic load(input logic [31:0] ms, tv, epc, cause);
        ld = 1'b1; ld_ms = ms; ld_tv = tv; ld_epc = epc; ld_cause = cause;
        cyc();
        ld = 1'b0;
        wq.delete();
    endtask

    task automatic fire(input logic il, ec, mr, input logic [31:0] pc);
        trap_valid = 1'b1;
        trap_is_illegal = il; trap_is_ecall = ec; trap_is_mret = mr;
        trap_pc = pc;
        cyc();
        trap_valid = 1'b0;
        trap_is_illegal = 0; trap_is_ecall = 0; trap_is_mret = 0;
    endtask

    task automatic wait_redir(output int lat);
        lat = 1;
        while (!redirect_valid && lat < 20) begin
            cyc();
            lat++;
        end
    endtask

    function automatic logic [31:0] trap_ms(input logic [31:0] ms);
        logic [31:0] r;
        r = ms & ~32'h0000_1888;
        r = r | (((ms >> 3) & 1) << 7) | (32'd3 << 11);
        return r;
    endfunction

    function automatic logic [31:0] mret_ms(input logic [31:0] ms);
        logic [31:0] r;
        r = ms & ~32'h0000_1888;
        r = r | (((ms >> 7) & 1) << 3) | (32'd1 << 7) | (32'd3 << 11);
        return r;
    endfunction

    typedef struct {
        logic        il, ec, mr;
        logic [31:0] pc, ms, tv, epc, cause;
        logic [31:0] e_tgt, e_ms, e_cause, e_epc;
        int          e_lat;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int lat;
        logic [31:0] rpc, pc2, ms, tv, epc;
        logic [2:0] k;
        logic [31:0] tgt;
        int elat;

        rst = 1'b1; ld = 1'b0;
        trap_valid = 0; trap_is_ecall = 0; trap_is_mret = 0;
        trap_is_illegal = 0; trap_pc = 0; redirect_ready = 1'b1;
        ld_ms = 0; ld_tv = 0; ld_epc = 0; ld_cause = 0;
        #1;
        chk("rst_ready", 32'(trap_ready), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_wen", 32'(csr_wen), 0);
        chk("rst_raddr", 32'(csr_raddr), 0);
        chk("rst_rvalid", 32'(redirect_valid), 0);
        chk("rst_rpc", redirect_pc, 0);
        cyc(); cyc();
        rst = 1'b0;

        tbl[0] = '{0,1,0, 32'h8000_0100, 32'h8, 32'h8000_0203, 32'h0, 32'h0,
                   32'h8000_0200, 32'h1880, 32'd11, 32'h8000_0100, 5};
        tbl[1] = '{0,0,1, 32'h0, 32'h1880, 32'h0, 32'h8000_0104, 32'h0,
                   32'h8000_0104, 32'h1888, 32'h0, 32'h8000_0104, 3};
        tbl[2] = '{1,1,0, 32'h8000_0200, 32'h0, 32'h8000_0000, 32'h0, 32'h0,
                   32'h8000_0000, 32'h1800, 32'd2, 32'h8000_0200, 5};
        tbl[3] = '{1,0,1, 32'h10, 32'h88, 32'h100, 32'h0, 32'h0,
                   32'h100, 32'h1880, 32'd2, 32'h10, 5};
        tbl[4] = '{0,1,1, 32'h20, 32'hFFFF_FFFF, 32'h13, 32'h0, 32'h0,
                   32'h10, 32'hFFFF_FFF7, 32'd11, 32'h20, 5};
        tbl[5] = '{0,0,1, 32'h0, 32'h8, 32'h0, 32'h44, 32'h5,
                   32'h44, 32'h1880, 32'h5, 32'h44, 3};

        for (int i = 0; i < 6; i++) begin
            load(tbl[i].ms, tbl[i].tv, tbl[i].epc, tbl[i].cause);
            fire(tbl[i].il, tbl[i].ec, tbl[i].mr, tbl[i].pc);
            wait_redir(lat);
            chk($sformatf("v%0d_lat", i), 32'(lat), 32'(tbl[i].e_lat));
            chk($sformatf("v%0d_rpc", i), redirect_pc, tbl[i].e_tgt);
            chk($sformatf("v%0d_ms", i), m_ms, tbl[i].e_ms);
            chk($sformatf("v%0d_cause", i), m_cause, tbl[i].e_cause);
            chk($sformatf("v%0d_epc", i), m_epc, tbl[i].e_epc);
            cyc();
            chk($sformatf("v%0d_idle", i), 32'(trap_ready), 1);
        end

        // trap_valid without a kind bit is ignored
        load(32'h8, 32'h100, 32'h0, 32'h0);
        trap_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("nokind_ready", 32'(trap_ready), 1);
        end
        trap_valid = 1'b0;
        chk("nokind_writes", 32'(wq.size()), 0);

        // redirect stall with a second event held by EXU
        load(32'h8, 32'h8000_0400, 32'h0, 32'h0);
        redirect_ready = 1'b0;
        fire(0, 1, 0, 32'h8000_0aa0);
        wait_redir(lat);
        chk("stall_lat", 32'(lat), 5);
        rpc = redirect_pc;
        chk("stall_rpc0", rpc, 32'h8000_0400);
        trap_valid = 1'b1; trap_is_mret = 1'b1; trap_pc = 32'h0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("stall_valid", 32'(redirect_valid), 1);
            chk("stall_rpc", redirect_pc, rpc);
            chk("stall_held", 32'(trap_ready), 0);
        end
        redirect_ready = 1'b1;
        cyc();
        chk("stall_idle", 32'(trap_ready), 1);
        chk("stall_not_yet", 32'(wq.size()), 3);
        cyc();
        trap_valid = 1'b0; trap_is_mret = 1'b0;
        wait_redir(lat);
        chk("held_lat", 32'(lat), 3);
        chk("held_rpc", redirect_pc, 32'h8000_0aa0);
        chk("held_writes", 32'(wq.size()), 4);
        cyc();

        // asynchronous reset while in W_STATUS
        load(32'h8, 32'h8000_0600, 32'h0, 32'h0);
        fire(0, 1, 0, 32'h8000_0bb0);
        cyc(); cyc();
        chk("mid_waddr", 32'(csr_waddr), 32'h300);
        rst = 1'b1;
        #1;
        chk("mid_wen", 32'(csr_wen), 0);
        chk("mid_waddr0", 32'(csr_waddr), 0);
        chk("mid_wdata0", csr_wdata, 0);
        chk("mid_raddr0", 32'(csr_raddr), 0);
        chk("mid_busy", 32'(busy), 0);
        chk("mid_ready", 32'(trap_ready), 1);
        chk("mid_rvalid", 32'(redirect_valid), 0);
        cyc();
        rst = 1'b0;
        chk("mid_epc", m_epc, 32'h8000_0bb0);
        chk("mid_cause", m_cause, 32'd11);
        chk("mid_ms", m_ms, 32'h8);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("mid_noredir", 32'(redirect_valid), 0);
        end
        fire(0, 1, 0, 32'h8000_0cc0);
        wait_redir(lat);
        chk("post_lat", 32'(lat), 5);
        chk("post_rpc", redirect_pc, 32'h8000_0600);
        chk("post_ms", m_ms, 32'h1880);
        cyc();

        // random traffic against the rule-level model
        for (int it = 0; it < 30; it++) begin
            ms = $urandom; tv = $urandom; epc = $urandom;
            pc2 = $urandom & ~32'h3;
            k = 3'($urandom_range(1, 7));
            load(ms, tv, epc, 32'h0);
            exp_q.delete();
            if (k[2] || k[1]) begin
                exp_q.push_back({12'h341, pc2});
                exp_q.push_back({12'h342, k[2] ? 32'd2 : 32'd11});
                exp_q.push_back({12'h300, trap_ms(ms)});
                tgt = tv - (tv % 4);
                elat = 5;
            end else begin
                exp_q.push_back({12'h300, mret_ms(ms)});
                tgt = epc;
                elat = 3;
            end
            fire(k[2], k[1], k[0], pc2);
            wait_redir(lat);
            chk("rnd_lat", 32'(lat), 32'(elat));
            chk("rnd_rpc", redirect_pc, tgt);
            chk("rnd_nwr", 32'(wq.size()), 32'(exp_q.size()));
            for (int j = 0; j < exp_q.size() && j < wq.size(); j++) begin
                chk("rnd_waddr", 32'(wq[j][43:32]), 32'(exp_q[j][43:32]));
                chk("rnd_wdata", wq[j][31:0], exp_q[j][31:0]);
            end
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
